// File: rtl/gp_cmd_pkg.sv
// Shared types and constants for the GP command store.
// Command layout: {addr[31:2], data[31:0], type[1:0]} = 64 bits.
package gp_cmd_pkg;

  localparam int unsigned CMD_W = 64;

  // Command type encodings; 2'b10 and 2'b11 are illegal.
  typedef enum logic [1:0] {
    WRITE = 2'b00,
    RWM   = 2'b01
  } cmd_type_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [1:0]  typ;
  } gp_cmd_t;

  // Block-relative register offsets.
  localparam logic [31:0] OFF_PUSH   = 32'h0;
  localparam logic [31:0] OFF_CTRL   = 32'h4;
  localparam logic [31:0] OFF_STATUS = 32'h8;

  typedef enum logic {
    IDLE     = 1'b0,
    LOW_HELD = 1'b1
  } push_state_e;

  // Source of the registered slave read data.
  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_STATUS = 2'd1,
    SEL_DBG    = 2'd2
  } rd_sel_e;

endpackage

// File: rtl/gp_cmd_store_if.sv
// Slave-side bus between the address decoder/AHB slave and gp_cmd_store.
// master: decoder side (drives select, valid, addr, data, direction)
// slave : command store (drives ready, read data, read valid)
interface gp_cmd_store_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cmd_en;
  logic                  slv_o_valid;
  logic [ADDR_WIDTH-1:0] slv_o_addr;
  logic [DATA_WIDTH-1:0] slv_o_wr_data;
  logic                  slv_o_rd0_wr1;
  logic                  slv_i_ready;
  logic [DATA_WIDTH-1:0] slv_i_rd_data;
  logic                  slv_i_rd_valid;

  modport master (
    output cmd_en, slv_o_valid, slv_o_addr, slv_o_wr_data, slv_o_rd0_wr1,
    input  slv_i_ready, slv_i_rd_data, slv_i_rd_valid
  );

  modport slave (
    input  cmd_en, slv_o_valid, slv_o_addr, slv_o_wr_data, slv_o_rd0_wr1,
    output slv_i_ready, slv_i_rd_data, slv_i_rd_valid
  );
endinterface

// File: rtl/gp_cmd_mem.sv
// Command storage: one write port, two synchronous read ports (FSM port A,
// debug port B), each with 1-cycle latency. Reads return the pre-write
// contents when they hit the entry being written in the same cycle.
// Optional parity column under GP_CMD_STORE_PARITY_EN (even parity, port A).
// Ports: clk, rst_n, we_i/waddr_i/wdata_i, re_a_i/raddr_a_i/rdata_a_o,
//        re_b_i/raddr_b_i/rdata_b_o, [perr_a_o].
module gp_cmd_mem
  import gp_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [CMD_W-1:0] wdata_i,
  input  logic             re_a_i,
  input  logic [IDX_W-1:0] raddr_a_i,
  output logic [CMD_W-1:0] rdata_a_o,
`ifdef GP_CMD_STORE_PARITY_EN
  output logic             perr_a_o,
`endif
  input  logic             re_b_i,
  input  logic [IDX_W-1:0] raddr_b_i,
  output logic [CMD_W-1:0] rdata_b_o
);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] rdata_a_q;
  logic [CMD_W-1:0] rdata_b_q;

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (re_a_i) rdata_a_q <= mem_q[raddr_a_i];
      if (re_b_i) rdata_b_q <= mem_q[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

`ifdef GP_CMD_STORE_PARITY_EN
  logic par_q [DEPTH];
  logic par_a_q;

  always_ff @(posedge clk) begin
    if (we_i) par_q[waddr_i] <= ^wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      par_a_q <= 1'b0;
    else if (re_a_i) par_a_q <= par_q[raddr_a_i];
  end

  assign perr_a_o = (^rdata_a_q) ^ par_a_q;
`endif

endmodule

// File: rtl/gp_cmd_store.sv
// GP engine command store: assembles pairs of 32-bit PUSH writes into 64-bit
// commands, checks RWM/WRITE sequencing, reports list status, serves the
// engine FSM through a 1-cycle read port, and offers debug read-back.
// Optional feature macro: GP_CMD_STORE_PARITY_EN (adds cmd_rd_perr and a
// sticky parity flag in STATUS above seq_err).
// Ports: clk, rst_n; slv (gp_cmd_store_if.slave); exec_busy;
//        cmd_rd_en/cmd_rd_idx -> cmd_rd_valid/cmd_out/cmd_rd_err[/cmd_rd_perr];
//        cmd_count, list_valid, seq_err, ovf_err status.
module gp_cmd_store
  import gp_cmd_pkg::*;
#(
  parameter int unsigned CMD_DEPTH  = 128,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_W      = $clog2(CMD_DEPTH),
  parameter logic [31:0] DBG_BASE   = 32'h100
) (
  input  logic               clk,
  input  logic               rst_n,
  gp_cmd_store_if.slave      slv,
  input  logic               exec_busy,
  input  logic               cmd_rd_en,
  input  logic [IDX_W-1:0]   cmd_rd_idx,
  output logic               cmd_rd_valid,
  output logic [CMD_W-1:0]   cmd_out,
  output logic               cmd_rd_err,
  output logic [IDX_W:0]     cmd_count,
  output logic               list_valid,
  output logic               seq_err,
  output logic               ovf_err
`ifdef GP_CMD_STORE_PARITY_EN
  ,
  output logic               cmd_rd_perr
`endif
);

  push_state_e           state_q, state_d;
  logic [IDX_W:0]        count_q, count_d;
  cmd_type_e             prev_q, prev_d;
  logic                  seq_q, seq_d;
  logic                  ovf_q, ovf_d;
  logic [31:0]           temp_q, temp_d;
  logic                  fsm_valid_q, fsm_err_q;
  logic                  rd_valid_q;
  rd_sel_e               rd_sel_q, rd_sel_d;
  logic [DATA_WIDTH-1:0] status_q, status_c;
  logic                  dbg_hi_q, dbg_ok_q;

  logic                  accept_c, wr_acc_c, rd_acc_c;
  logic                  is_push_c, is_ctrl_c, is_status_c, is_dbg_c;
  logic [ADDR_WIDTH-1:0] dbg_off_c;
  logic [IDX_W-1:0]      dbg_idx_c;
  logic                  list_valid_c;
  logic [1:0]            new_type_c;
  gp_cmd_t               entry_c;
  logic                  mem_we_c;
  logic [CMD_W-1:0]      mem_a, mem_b;
  logic [DATA_WIDTH-1:0] rd_data_c;

  // Writes stall while the engine executes; reads never stall.
  assign slv.slv_i_ready = slv.slv_o_rd0_wr1 ? !exec_busy : 1'b1;
  assign accept_c        = slv.cmd_en && slv.slv_o_valid && slv.slv_i_ready;
  assign wr_acc_c        = accept_c && slv.slv_o_rd0_wr1;
  assign rd_acc_c        = accept_c && !slv.slv_o_rd0_wr1;

  // Address decode, including the debug window of 8 bytes per entry.
  assign is_push_c   = slv.slv_o_addr == ADDR_WIDTH'(OFF_PUSH);
  assign is_ctrl_c   = slv.slv_o_addr == ADDR_WIDTH'(OFF_CTRL);
  assign is_status_c = slv.slv_o_addr == ADDR_WIDTH'(OFF_STATUS);
  assign dbg_off_c   = slv.slv_o_addr - ADDR_WIDTH'(DBG_BASE);
  assign is_dbg_c    = (slv.slv_o_addr >= ADDR_WIDTH'(DBG_BASE)) &&
                       ((dbg_off_c >> (IDX_W + 3)) == '0);
  assign dbg_idx_c   = dbg_off_c[IDX_W+2:3];

  assign list_valid_c = (count_q != '0) && (prev_q == WRITE) && !seq_q && !ovf_q;

  assign new_type_c   = slv.slv_o_wr_data[1:0];
  assign entry_c.addr = slv.slv_o_wr_data[31:2];
  assign entry_c.data = temp_q;
  assign entry_c.typ  = new_type_c;

`ifdef GP_CMD_STORE_PARITY_EN
  logic perr_q, perr_d, mem_perr_a;
  assign cmd_rd_perr = fsm_valid_q && !fsm_err_q && mem_perr_a;
  assign status_c    = DATA_WIDTH'({perr_q, seq_q, ovf_q, list_valid_c, count_q});
`else
  assign status_c    = DATA_WIDTH'({seq_q, ovf_q, list_valid_c, count_q});
`endif

  // Push FSM and list bookkeeping; CTRL clear overrides any held half.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    prev_d   = prev_q;
    seq_d    = seq_q;
    ovf_d    = ovf_q;
    temp_d   = temp_q;
    mem_we_c = 1'b0;
`ifdef GP_CMD_STORE_PARITY_EN
    perr_d   = perr_q | cmd_rd_perr;
`endif
    if (wr_acc_c && is_ctrl_c && slv.slv_o_wr_data[0]) begin
      state_d = IDLE;
      count_d = '0;
      prev_d  = WRITE;
      seq_d   = 1'b0;
      ovf_d   = 1'b0;
`ifdef GP_CMD_STORE_PARITY_EN
      perr_d  = 1'b0;
`endif
    end else if (wr_acc_c && is_push_c) begin
      case (state_q)
        IDLE: begin
          temp_d  = slv.slv_o_wr_data[31:0];
          state_d = LOW_HELD;
        end
        LOW_HELD: begin
          state_d = IDLE;
          if (new_type_c[1] || (prev_q == RWM && new_type_c == 2'b01)) begin
            seq_d = 1'b1;
          end else if (count_q == (IDX_W+1)'(CMD_DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            mem_we_c = 1'b1;
            count_d  = count_q + (IDX_W+1)'(1);
            prev_d   = cmd_type_e'(new_type_c);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered slave-read source selection.
  always_comb begin
    rd_sel_d = SEL_NONE;
    if (rd_acc_c) begin
      if (is_status_c)   rd_sel_d = SEL_STATUS;
      else if (is_dbg_c) rd_sel_d = SEL_DBG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      prev_q      <= WRITE;
      seq_q       <= 1'b0;
      ovf_q       <= 1'b0;
      temp_q      <= '0;
      fsm_valid_q <= 1'b0;
      fsm_err_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_sel_q    <= SEL_NONE;
      status_q    <= '0;
      dbg_hi_q    <= 1'b0;
      dbg_ok_q    <= 1'b0;
`ifdef GP_CMD_STORE_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      prev_q      <= prev_d;
      seq_q       <= seq_d;
      ovf_q       <= ovf_d;
      temp_q      <= temp_d;
      fsm_valid_q <= cmd_rd_en;
      fsm_err_q   <= cmd_rd_en && ({1'b0, cmd_rd_idx} >= count_q);
      rd_valid_q  <= rd_acc_c;
      rd_sel_q    <= rd_sel_d;
      status_q    <= status_c;
      dbg_hi_q    <= dbg_off_c[2];
      dbg_ok_q    <= {1'b0, dbg_idx_c} < count_q;
`ifdef GP_CMD_STORE_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  end

  gp_cmd_mem #(
    .DEPTH (CMD_DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (mem_we_c),
    .waddr_i   (count_q[IDX_W-1:0]),
    .wdata_i   (entry_c),
    .re_a_i    (cmd_rd_en),
    .raddr_a_i (cmd_rd_idx),
    .rdata_a_o (mem_a),
`ifdef GP_CMD_STORE_PARITY_EN
    .perr_a_o  (mem_perr_a),
`endif
    .re_b_i    (rd_acc_c && is_dbg_c),
    .raddr_b_i (dbg_idx_c),
    .rdata_b_o (mem_b)
  );

  // Debug reads of uncommitted entries and unmapped offsets return zero.
  always_comb begin
    rd_data_c = '0;
    case (rd_sel_q)
      SEL_STATUS: rd_data_c = status_q;
      SEL_DBG:    if (dbg_ok_q) rd_data_c = dbg_hi_q ? DATA_WIDTH'(mem_b[63:32])
                                                     : DATA_WIDTH'(mem_b[31:0]);
      default:    rd_data_c = '0;
    endcase
  end

  assign slv.slv_i_rd_data  = rd_data_c;
  assign slv.slv_i_rd_valid = rd_valid_q;

  assign cmd_rd_valid = fsm_valid_q;
  assign cmd_rd_err   = fsm_valid_q && fsm_err_q;
  assign cmd_out      = fsm_valid_q ? mem_a : '0;
  assign cmd_count    = count_q;
  assign list_valid   = list_valid_c;
  assign seq_err      = seq_q;
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_gp_cmd_store.sv
module tb_gp_cmd_store;

  logic        clk;
  logic        rst_n;
  logic        exec_busy;
  logic        cmd_rd_en;
  logic [6:0]  cmd_rd_idx;
  logic        cmd_rd_valid;
  logic [63:0] cmd_out;
  logic        cmd_rd_err;
  logic [7:0]  cmd_count;
  logic        list_valid;
  logic        seq_err;
  logic        ovf_err;
`ifdef GP_CMD_STORE_PARITY_EN
  logic        cmd_rd_perr;
`endif

  int total = 0;
  int bad   = 0;

  gp_cmd_store_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  gp_cmd_store dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .slv          (bus),
    .exec_busy    (exec_busy),
    .cmd_rd_en    (cmd_rd_en),
    .cmd_rd_idx   (cmd_rd_idx),
    .cmd_rd_valid (cmd_rd_valid),
    .cmd_out      (cmd_out),
    .cmd_rd_err   (cmd_rd_err),
    .cmd_count    (cmd_count),
    .list_valid   (list_valid),
    .seq_err      (seq_err),
    .ovf_err      (ovf_err)
`ifdef GP_CMD_STORE_PARITY_EN
    ,
    .cmd_rd_perr  (cmd_rd_perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    bus.cmd_en = 1'b1; bus.slv_o_valid = 1'b1; bus.slv_o_addr = a;
    bus.slv_o_wr_data = d; bus.slv_o_rd0_wr1 = 1'b1;
    while (!bus.slv_i_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL write_timeout: addr %h not accepted in 200 cycles", a);
    end
    @(posedge clk); #1;
    bus.cmd_en = 1'b0; bus.slv_o_valid = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d,
                          output logic v1, output logic v2);
    @(negedge clk);
    bus.cmd_en = 1'b1; bus.slv_o_valid = 1'b1; bus.slv_o_addr = a;
    bus.slv_o_rd0_wr1 = 1'b0;
    @(posedge clk); #1;
    bus.cmd_en = 1'b0; bus.slv_o_valid = 1'b0;
    @(negedge clk);
    v1 = bus.slv_i_rd_valid; d = bus.slv_i_rd_data;
    @(negedge clk);
    v2 = bus.slv_i_rd_valid;
  endtask

  task automatic fsm_read(input int idx, output logic v, output logic [63:0] o,
                          output logic e);
    @(negedge clk);
    cmd_rd_en = 1'b1; cmd_rd_idx = 7'(idx);
    @(negedge clk);
    cmd_rd_en = 1'b0;
    v = cmd_rd_valid; o = cmd_out; e = cmd_rd_err;
  endtask

  task automatic test_reset;
    total++; if (bus.slv_i_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.slv_i_ready); end
    total++; if (bus.slv_i_rd_valid !== 1'b0 || bus.slv_i_rd_data !== 32'h0) begin bad++; $display("FAIL rst_rd: got %b/%h want 0/0", bus.slv_i_rd_valid, bus.slv_i_rd_data); end
    total++; if (cmd_rd_valid !== 1'b0 || cmd_out !== 64'h0 || cmd_rd_err !== 1'b0) begin bad++; $display("FAIL rst_fsm: got %b/%h/%b want 0/0/0", cmd_rd_valid, cmd_out, cmd_rd_err); end
    total++; if ({cmd_count, list_valid, seq_err, ovf_err} !== 11'h0) begin bad++; $display("FAIL rst_status: got cnt=%h lv=%b seq=%b ovf=%b want all 0", cmd_count, list_valid, seq_err, ovf_err); end
  endtask

  task automatic test_push_basic;
    logic v, e; logic [63:0] o;
    bus_write(32'h0, 32'hDEAD_BEEF);
    bus_write(32'h0, 32'h0000_1000);
    @(negedge clk);
    total++; if (cmd_count !== 8'd1 || list_valid !== 1'b1) begin bad++; $display("FAIL push_count: got cnt=%0d lv=%b want 1/1", cmd_count, list_valid); end
    fsm_read(0, v, o, e);
    total++; if (v !== 1'b1 || o !== 64'h0000_1003_7AB6_FBBC || e !== 1'b0) begin bad++; $display("FAIL push_fsm_read: got v=%b out=%h err=%b want 1/00001003_7ab6fbbc/0", v, o, e); end
    @(negedge clk);
    total++; if (cmd_rd_valid !== 1'b0 || cmd_out !== 64'h0) begin bad++; $display("FAIL fsm_read_idle: got v=%b out=%h want 0/0", cmd_rd_valid, cmd_out); end
  endtask

  task automatic test_debug;
    logic [31:0] d; logic v1, v2, v, e; logic [63:0] o;
    bus_read(32'h104, d, v1, v2);
    total++; if (d !== 32'h0000_1003 || v1 !== 1'b1 || v2 !== 1'b0) begin bad++; $display("FAIL dbg_hi: got d=%h v=%b%b want 00001003 v=10", d, v1, v2); end
    bus_read(32'h100, d, v1, v2);
    total++; if (d !== 32'h7AB6_FBBC || v1 !== 1'b1) begin bad++; $display("FAIL dbg_lo: got d=%h v=%b want 7ab6fbbc 1", d, v1); end
    bus_read(32'h128, d, v1, v2);
    total++; if (d !== 32'h0 || v1 !== 1'b1 || v2 !== 1'b0) begin bad++; $display("FAIL dbg_idx5: got d=%h v=%b%b want 0 v=10", d, v1, v2); end
    bus_read(32'h8, d, v1, v2);
    total++; if (d !== 32'h0000_0101 || v1 !== 1'b1) begin bad++; $display("FAIL status1: got %h want 00000101", d); end
    bus_read(32'h40, d, v1, v2);
    total++; if (d !== 32'h0 || v1 !== 1'b1 || v2 !== 1'b0) begin bad++; $display("FAIL unmapped_rd: got d=%h v=%b%b want 0 v=10", d, v1, v2); end
    fsm_read(3, v, o, e);
    total++; if (v !== 1'b1 || e !== 1'b1) begin bad++; $display("FAIL fsm_idx3_err: got v=%b err=%b want 1/1", v, e); end
    bus_write(32'h8, 32'hFFFF_FFFF);
    bus_write(32'h40, 32'h1234_5678);
    @(negedge clk);
    total++; if (cmd_count !== 8'd1 || list_valid !== 1'b1 || seq_err !== 1'b0) begin bad++; $display("FAIL ro_write_ignored: got cnt=%0d lv=%b seq=%b want 1/1/0", cmd_count, list_valid, seq_err); end
  endtask

  task automatic test_seq_err;
    logic [31:0] d; logic v1, v2;
    bus_write(32'h4, 32'h1);
    @(negedge clk);
    total++; if (cmd_count !== 8'd0) begin bad++; $display("FAIL clear0: got cnt=%0d want 0", cmd_count); end
    bus_write(32'h0, 32'h0000_0001);
    bus_write(32'h0, 32'h0000_2001);
    @(negedge clk);
    total++; if (cmd_count !== 8'd1 || list_valid !== 1'b0 || seq_err !== 1'b0) begin bad++; $display("FAIL rwm_first: got cnt=%0d lv=%b seq=%b want 1/0/0", cmd_count, list_valid, seq_err); end
    bus_write(32'h0, 32'h0000_0002);
    bus_write(32'h0, 32'h0000_3001);
    @(negedge clk);
    total++; if (cmd_count !== 8'd1 || list_valid !== 1'b0 || seq_err !== 1'b1) begin bad++; $display("FAIL rwm_rwm: got cnt=%0d lv=%b seq=%b want 1/0/1", cmd_count, list_valid, seq_err); end
    bus_read(32'h8, d, v1, v2);
    total++; if (d !== 32'h0000_0401) begin bad++; $display("FAIL status_seq: got %h want 00000401", d); end
    bus_write(32'h4, 32'h1);
    @(negedge clk);
    total++; if (cmd_count !== 8'd0 || seq_err !== 1'b0 || ovf_err !== 1'b0 || list_valid !== 1'b0) begin bad++; $display("FAIL clear_seq: got cnt=%0d seq=%b ovf=%b lv=%b want 0/0/0/0", cmd_count, seq_err, ovf_err, list_valid); end
    bus_write(32'h0, 32'h0000_0003);
    bus_write(32'h0, 32'h0000_4002);
    @(negedge clk);
    total++; if (cmd_count !== 8'd0 || seq_err !== 1'b1) begin bad++; $display("FAIL bad_type: got cnt=%0d seq=%b want 0/1", cmd_count, seq_err); end
    bus_write(32'h4, 32'h1);
  endtask

  task automatic test_busy;
    logic v, e; logic [63:0] o;
    @(negedge clk);
    exec_busy = 1'b1;
    bus.cmd_en = 1'b1; bus.slv_o_valid = 1'b1; bus.slv_o_addr = 32'h0;
    bus.slv_o_wr_data = 32'hAAAA_AAA8; bus.slv_o_rd0_wr1 = 1'b1;
    #1;
    total++; if (bus.slv_i_ready !== 1'b0) begin bad++; $display("FAIL busy_ready: got %b want 0", bus.slv_i_ready); end
    repeat (3) @(negedge clk);
    bus.slv_o_valid = 1'b0; bus.slv_o_rd0_wr1 = 1'b0;
    #1;
    total++; if (bus.slv_i_ready !== 1'b1) begin bad++; $display("FAIL busy_read_ready: got %b want 1", bus.slv_i_ready); end
    bus.slv_o_valid = 1'b1; bus.slv_o_rd0_wr1 = 1'b1;
    total++; if (cmd_count !== 8'd0) begin bad++; $display("FAIL busy_stall_cnt: got %0d want 0", cmd_count); end
    exec_busy = 1'b0;
    @(posedge clk); #1;
    bus.cmd_en = 1'b0; bus.slv_o_valid = 1'b0;
    @(negedge clk);
    total++; if (cmd_count !== 8'd0) begin bad++; $display("FAIL busy_once: got %0d want 0", cmd_count); end
    bus_write(32'h0, 32'h0000_8000);
    @(negedge clk);
    total++; if (cmd_count !== 8'd1 || list_valid !== 1'b1) begin bad++; $display("FAIL busy_commit: got cnt=%0d lv=%b want 1/1", cmd_count, list_valid); end
    fsm_read(0, v, o, e);
    total++; if (o !== 64'h0000_8002_AAAA_AAA0 || v !== 1'b1) begin bad++; $display("FAIL busy_entry: got %h want 00008002_aaaaaaa0", o); end
    bus_write(32'h4, 32'h1);
  endtask

  task automatic test_overflow;
    logic v, e; logic [63:0] o, exp_e; logic [31:0] d, exp_hi; logic v1, v2;
    for (int i = 0; i < 128; i++) begin
      bus_write(32'h0, 32'hCAFE_0000 + 32'(i));
      bus_write(32'h0, 32'(i) << 4);
    end
    @(negedge clk);
    total++; if (cmd_count !== 8'h80 || list_valid !== 1'b1 || ovf_err !== 1'b0) begin bad++; $display("FAIL full: got cnt=%h lv=%b ovf=%b want 80/1/0", cmd_count, list_valid, ovf_err); end
    bus_write(32'h0, 32'h1234_5678);
    bus_write(32'h0, 32'h0000_FFFC);
    @(negedge clk);
    total++; if (cmd_count !== 8'h80 || list_valid !== 1'b0 || ovf_err !== 1'b1) begin bad++; $display("FAIL ovf: got cnt=%h lv=%b ovf=%b want 80/0/1", cmd_count, list_valid, ovf_err); end
    exp_e = {30'h1FC, 32'hCAFE_007F, 2'b00};
    fsm_read(127, v, o, e);
    total++; if (o !== exp_e || e !== 1'b0) begin bad++; $display("FAIL last_entry: got %h err=%b want %h 0", o, e, exp_e); end
    exp_hi = exp_e[63:32];
    bus_read(32'h4FC, d, v1, v2);
    total++; if (d !== exp_hi) begin bad++; $display("FAIL dbg_last_hi: got %h want %h", d, exp_hi); end
    bus_read(32'h8, d, v1, v2);
    total++; if (d !== 32'h0000_0280) begin bad++; $display("FAIL status_ovf: got %h want 00000280", d); end
  endtask

  task automatic test_reset_mid_push;
    logic v, e; logic [63:0] o;
    bus_write(32'h0, 32'h5555_5555);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (cmd_count !== 8'd0 || ovf_err !== 1'b0 || list_valid !== 1'b0) begin bad++; $display("FAIL async_rst: got cnt=%0d ovf=%b lv=%b want 0/0/0", cmd_count, ovf_err, list_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_write(32'h0, 32'h0BAD_F00D);
    bus_write(32'h0, 32'h0000_4000);
    @(negedge clk);
    total++; if (cmd_count !== 8'd1) begin bad++; $display("FAIL post_rst_cnt: got %0d want 1", cmd_count); end
    fsm_read(0, v, o, e);
    total++; if (o !== 64'h0000_4000_2EB7_C034) begin bad++; $display("FAIL post_rst_entry: got %h want 00004000_2eb7c034", o); end
  endtask

  task automatic test_back_to_back;
    logic v, e; logic [63:0] o, exp_old;
    bus_write(32'h0, 32'h9999_9999);
    bus_write(32'h4, 32'h1);
    @(negedge clk);
    total++; if (cmd_count !== 8'd0) begin bad++; $display("FAIL clr_half_cnt: got %0d want 0", cmd_count); end
    bus_write(32'h0, 32'h0000_0011);
    bus_write(32'h0, 32'h0000_0020);
    fsm_read(0, v, o, e);
    total++; if (o !== 64'h0000_0020_0000_0044 || cmd_count !== 8'd1) begin bad++; $display("FAIL clr_half_entry: got %h cnt=%0d want 00000020_00000044 1", o, cmd_count); end
    bus_write(32'h0, 32'h7777_7777);
    @(negedge clk);
    bus.cmd_en = 1'b1; bus.slv_o_valid = 1'b1; bus.slv_o_addr = 32'h0;
    bus.slv_o_wr_data = 32'h0; bus.slv_o_rd0_wr1 = 1'b1;
    cmd_rd_en = 1'b1; cmd_rd_idx = 7'd1;
    @(posedge clk); #1;
    bus.cmd_en = 1'b0; bus.slv_o_valid = 1'b0;
    @(negedge clk);
    cmd_rd_en = 1'b0;
    exp_old = {30'd4, 32'hCAFE_0001, 2'b00};
    total++; if (cmd_rd_valid !== 1'b1 || cmd_out !== exp_old || cmd_rd_err !== 1'b1) begin bad++; $display("FAIL rbw_old: got v=%b out=%h err=%b want 1/%h/1", cmd_rd_valid, cmd_out, cmd_rd_err, exp_old); end
    total++; if (cmd_count !== 8'd2) begin bad++; $display("FAIL rbw_cnt: got %0d want 2", cmd_count); end
    fsm_read(1, v, o, e);
    total++; if (o !== 64'h0000_0001_DDDD_DDDC || e !== 1'b0) begin bad++; $display("FAIL rbw_new: got %h err=%b want 00000001_dddddddc 0", o, e); end
  endtask

  initial begin
    rst_n = 1'b0; exec_busy = 1'b0; cmd_rd_en = 1'b0; cmd_rd_idx = '0;
    bus.cmd_en = 1'b0; bus.slv_o_valid = 1'b0; bus.slv_o_addr = '0;
    bus.slv_o_wr_data = '0; bus.slv_o_rd0_wr1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_push_basic();
    test_debug();
    test_seq_err();
    test_busy();
    test_overflow();
    test_reset_mid_push();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
